// File: rtl/ad1939_spi_config_seq.sv
// AD1939 control-port sequencer: after the power-on wait it writes every register-table entry
// over the codec SPI port, then serves single-register runtime writes via req/ack.
// Optional build macro READBACK_VERIFY_EN adds a read frame after each verified table write,
// compares the read data with the written data, and reports the first mismatch.
module ad1939_spi_config_seq #(
   parameter int unsigned CLK_DIV    = 8,
   parameter int unsigned NUM_REGS   = 17,
   parameter int unsigned POR_WAIT   = 4096,
   parameter int unsigned GAP_CYCLES = 16,
   parameter logic [6:0]  CHIP_ADDR  = 7'h04
) (
   input  logic        clk_clk,
   input  logic        reset_reset_n,
   input  logic        start,
   output logic [4:0]  tbl_idx,
   input  logic [16:0] tbl_data,
   input  logic        wr_req,
   input  logic [7:0]  wr_addr,
   input  logic [7:0]  wr_data,
   output logic        wr_ack,
   output logic        busy,
   output logic        ready,
   output logic        error,
   output logic [4:0]  err_idx,
   output logic        clatch_n,
   output logic        cclk,
   output logic        cin,
   input  logic        cout
);

   typedef enum logic [2:0] {StPor, StFetch, StLoad, StShift, StGap, StReady} state_e;

   localparam int unsigned CntW = $clog2(POR_WAIT + CLK_DIV + GAP_CYCLES + 1);
   localparam logic [CntW-1:0] PorLast = CntW'(POR_WAIT - 1);
   localparam logic [CntW-1:0] DivLast = CntW'(CLK_DIV - 1);
   localparam logic [CntW-1:0] GapLast = CntW'(GAP_CYCLES - 1);
   localparam logic [4:0]      IdxLast = 5'(NUM_REGS - 1);

   state_e          state_q;
   logic [CntW-1:0] cnt_q;
   logic [4:0]      bit_q;
   logic [23:0]     sr_q;
   logic [4:0]      idx_q;
   logic            rt_q;
   logic            ack_q, busy_q, ready_q;
   logic            cl_q, cclk_q, cin_q;
`ifdef READBACK_VERIFY_EN
   logic            rd_q;
   logic            nover_q;
   logic [7:0]      addr_q, data_q, rdat_q;
   logic            err_q;
   logic [4:0]      erridx_q;
`else
   logic            unused_in;
   assign unused_in = ^{cout, tbl_data[16]};
`endif

   // Sequencer FSM with all SPI and handshake outputs registered.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         state_q  <= StPor;
         cnt_q    <= '0;
         bit_q    <= 5'd23;
         sr_q     <= '0;
         idx_q    <= '0;
         rt_q     <= 1'b0;
         ack_q    <= 1'b0;
         busy_q   <= 1'b1;
         ready_q  <= 1'b0;
         cl_q     <= 1'b1;
         cclk_q   <= 1'b0;
         cin_q    <= 1'b0;
`ifdef READBACK_VERIFY_EN
         rd_q     <= 1'b0;
         nover_q  <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         rdat_q   <= '0;
         err_q    <= 1'b0;
         erridx_q <= '0;
`endif
      end else begin
         ack_q <= 1'b0;
         unique case (state_q)
            StPor: begin
               if (cnt_q == PorLast) begin
                  cnt_q   <= '0;
                  state_q <= StFetch;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            // tbl_data for the current index becomes valid one cycle after tbl_idx
            StFetch: state_q <= StLoad;
            StLoad: begin
               if (rt_q) begin
                  sr_q <= {CHIP_ADDR, 1'b0, wr_addr, wr_data};
               end
`ifdef READBACK_VERIFY_EN
               else if (rd_q) begin
                  sr_q <= {CHIP_ADDR, 1'b1, addr_q, 8'h00};
               end
`endif
               else begin
                  sr_q <= {CHIP_ADDR, 1'b0, tbl_data[15:0]};
`ifdef READBACK_VERIFY_EN
                  addr_q  <= tbl_data[15:8];
                  data_q  <= tbl_data[7:0];
                  nover_q <= tbl_data[16];
`endif
               end
               cin_q   <= CHIP_ADDR[6];
               cl_q    <= 1'b0;
               cnt_q   <= '0;
               bit_q   <= 5'd23;
               state_q <= StShift;
            end
            StShift: begin
               if (cnt_q == DivLast) begin
                  cnt_q <= '0;
                  if (!cclk_q) begin
                     cclk_q <= 1'b1;
`ifdef READBACK_VERIFY_EN
                     if (bit_q < 5'd8) rdat_q <= {rdat_q[6:0], cout};
`endif
                  end else begin
                     cclk_q <= 1'b0;
                     if (bit_q == 5'd0) begin
                        cl_q    <= 1'b1;
                        cin_q   <= 1'b0;
                        state_q <= StGap;
`ifdef READBACK_VERIFY_EN
                        if (rd_q && (rdat_q != data_q) && !err_q) begin
                           err_q    <= 1'b1;
                           erridx_q <= idx_q;
                        end
`endif
                     end else begin
                        bit_q <= bit_q - 5'd1;
                        cin_q <= sr_q[22];
                        sr_q  <= {sr_q[22:0], 1'b0};
                     end
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StGap: begin
               if (cnt_q == GapLast) begin
                  cnt_q <= '0;
                  if (rt_q) begin
                     rt_q    <= 1'b0;
                     busy_q  <= 1'b0;
                     ready_q <= 1'b1;
                     state_q <= StReady;
                  end
`ifdef READBACK_VERIFY_EN
                  else if (!rd_q && !nover_q) begin
                     rd_q    <= 1'b1;
                     state_q <= StLoad;
                  end
`endif
                  else begin
`ifdef READBACK_VERIFY_EN
                     rd_q <= 1'b0;
`endif
                     if (idx_q == IdxLast) begin
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= StReady;
                     end else begin
                        idx_q   <= idx_q + 5'd1;
                        state_q <= StFetch;
                     end
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StReady: begin
               // start has priority; a concurrent wr_req stays pending
               if (start) begin
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  ready_q <= 1'b0;
                  state_q <= StFetch;
               end else if (wr_req) begin
                  ack_q   <= 1'b1;
                  rt_q    <= 1'b1;
                  busy_q  <= 1'b1;
                  ready_q <= 1'b0;
                  state_q <= StLoad;
               end
            end
            default: state_q <= StPor;
         endcase
      end
   end

   assign tbl_idx  = idx_q;
   assign wr_ack   = ack_q;
   assign busy     = busy_q;
   assign ready    = ready_q;
   assign clatch_n = cl_q;
   assign cclk     = cclk_q;
   assign cin      = cin_q;
`ifdef READBACK_VERIFY_EN
   assign error    = err_q;
   assign err_idx  = erridx_q;
`else
   assign error    = 1'b0;
   assign err_idx  = 5'd0;
`endif

endmodule

// File: tb/tb_ad1939_spi_config_seq.sv
// Scoreboard bench for ad1939_spi_config_seq: stimulus pushes expected SPI frames, a monitor
// decodes clatch_n/cclk/cin and pops/compares each completed frame. A small codec model answers
// read frames (addr 0x01 reads back with bit 0 flipped). Honours READBACK_VERIFY_EN.
module tb_ad1939_spi_config_seq;
   localparam int unsigned ClkDiv    = 2;
   localparam int unsigned PorWait   = 8;
   localparam int unsigned GapCycles = 4;
`ifdef READBACK_VERIFY_EN
   localparam int unsigned NumRegs   = 3;
`else
   localparam int unsigned NumRegs   = 2;
`endif

   logic        clk = 1'b0;
   logic        rst_n, start, wr_req, cout;
   logic [7:0]  wr_addr, wr_data;
   logic [4:0]  tbl_idx, err_idx;
   logic [16:0] tbl_data = '0;
   logic        wr_ack, busy, ready, error, clatch_n, cclk, cin;

   int n_checks = 0;
   int n_fail   = 0;
   logic [23:0] exp_q [$];
   logic        aborting = 1'b0;
   int          mon_rises = 0;
   int          gap_bad = 0;

   always #5 clk = ~clk;

   ad1939_spi_config_seq #(
      .CLK_DIV(ClkDiv), .NUM_REGS(NumRegs), .POR_WAIT(PorWait),
      .GAP_CYCLES(GapCycles), .CHIP_ADDR(7'h04)
   ) dut (
      .clk_clk(clk), .reset_reset_n(rst_n), .start(start), .tbl_idx(tbl_idx),
      .tbl_data(tbl_data), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_ack(wr_ack), .busy(busy), .ready(ready), .error(error), .err_idx(err_idx),
      .clatch_n(clatch_n), .cclk(cclk), .cin(cin), .cout(cout)
   );

   function automatic logic [16:0] tbl_entry(input logic [4:0] i);
      case (i)
         5'd0:    return 17'h00080;
         5'd1:    return 17'h00104;
         5'd2:    return 17'h10203;
         default: return 17'h00000;
      endcase
   endfunction

   function automatic logic [23:0] wframe(input logic [7:0] a, input logic [7:0] d);
      return {7'h04, 1'b0, a, d};
   endfunction

   // External table memory with one cycle of read latency.
   always @(posedge clk) tbl_data <= tbl_entry(tbl_idx);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_table();
      logic [16:0] e;
      for (int i = 0; i < NumRegs; i++) begin
         e = tbl_entry(5'(i));
         exp_q.push_back(wframe(e[15:8], e[7:0]));
`ifdef READBACK_VERIFY_EN
         if (!e[16]) exp_q.push_back({7'h04, 1'b1, e[15:8], 8'h00});
`endif
      end
   endtask

   // Codec model: register file written by write frames, cout driven on cclk falls.
   logic [23:0] m_sh = '0;
   int          m_cnt = 0;
   logic [7:0]  m_val = '0;
   logic [7:0]  codec_mem [256];
   initial begin
      cout = 1'b0;
      for (int i = 0; i < 256; i++) codec_mem[i] = 8'h00;
   end
   always @(negedge clatch_n) begin
      m_cnt = 0;
      m_sh  = '0;
   end
   always @(posedge cclk) begin
      m_sh = {m_sh[22:0], cin};
      m_cnt++;
   end
   always @(negedge cclk) begin
      if (m_cnt == 16)
         m_val = (m_sh[7:0] == 8'h01) ? (codec_mem[m_sh[7:0]] ^ 8'h01) : codec_mem[m_sh[7:0]];
      if (m_cnt >= 16 && m_cnt < 24) cout = m_val[3'(23 - m_cnt)];
   end
   always @(posedge clatch_n) begin
      if (m_cnt == 24 && !m_sh[16]) codec_mem[m_sh[15:8]] = m_sh[7:0];
   end

   // Monitor: decode frames on the falling clk edge and score them against the queue.
   logic        p_cl = 1'b1, p_cclk = 1'b0, p_cin = 1'b0;
   int          spc = 0, lowc = 0, highc = 0;
   logic [23:0] cap = '0;
   logic        spc_ok = 1'b1, cin_ok = 1'b1;
   logic [23:0] e_fr;
   always @(negedge clk) begin
      if (clatch_n === 1'b1 && (cclk !== 1'b0 || cin !== 1'b0)) gap_bad++;
      if (p_cl === 1'b0) begin
         spc++;
         if (cclk !== p_cclk) begin
            if (spc != ClkDiv) spc_ok = 1'b0;
            spc = 0;
         end
         if (cclk === 1'b1 && p_cclk === 1'b0) begin
            mon_rises++;
            cap = {cap[22:0], cin};
            if (cin !== p_cin) cin_ok = 1'b0;
         end
      end
      if (p_cl === 1'b1 && clatch_n === 1'b0) begin
         check("gap_len", 32'(highc >= GapCycles), 1);
         spc = 0; lowc = 0; highc = 0; mon_rises = 0; cap = '0;
         spc_ok = 1'b1; cin_ok = 1'b1;
      end
      if (clatch_n === 1'b0) lowc++;
      if (clatch_n === 1'b1) highc++;
      if (p_cl === 1'b0 && clatch_n === 1'b1) begin
         if (aborting) begin
            aborting = 1'b0;
         end else begin
            check("frame_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e_fr = exp_q.pop_front();
               check("frame", 32'(cap), 32'(e_fr));
               check("rises", mon_rises, 24);
               check("low_cycles", lowc, 48 * ClkDiv);
               check("cclk_spacing", 32'(spc_ok), 1);
               check("cin_stable", 32'(cin_ok), 1);
            end
         end
      end
      p_cl = clatch_n; p_cclk = cclk; p_cin = cin;
   end

   task automatic count_por(input string name);
      int n = 0;
      while (clatch_n !== 1'b0 && n < 100) begin
         @(posedge clk); #1; n++;
      end
      check(name, n, PorWait + 2);
   endtask

   task automatic wait_ready(input string name);
      int n = 0;
      while (ready !== 1'b1 && n < 3000) begin
         @(posedge clk); #1; n++;
      end
      check(name, 32'(ready), 1);
      check({name, "_busy"}, 32'(busy), 0);
      check({name, "_idx"}, 32'(tbl_idx), 0);
   endtask

   task automatic wait_ack(input string name, output logic seen_ready);
      int n = 0;
      seen_ready = 1'b0;
      while (wr_ack !== 1'b1 && n < 3000) begin
         @(posedge clk); #1; n++;
         if (ready === 1'b1) seen_ready = 1'b1;
      end
      check(name, 32'(wr_ack), 1);
   endtask

   logic sr;
   int   n_w;
   initial begin
      rst_n = 1'b0; start = 1'b0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_clatch_n", 32'(clatch_n), 1);
      check("rst_cclk", 32'(cclk), 0);
      check("rst_cin", 32'(cin), 0);
      check("rst_tbl_idx", 32'(tbl_idx), 0);
      check("rst_wr_ack", 32'(wr_ack), 0);
      check("rst_busy", 32'(busy), 1);
      check("rst_ready", 32'(ready), 0);
      check("rst_error", 32'(error), 0);
      check("rst_err_idx", 32'(err_idx), 0);

      // Power-on table run
      push_table();
      @(negedge clk); rst_n = 1'b1;
      count_por("por_latency");
      wait_ready("table_ready");
`ifdef READBACK_VERIFY_EN
      check("verify_error", 32'(error), 1);
      check("verify_err_idx", 32'(err_idx), 1);
`else
      check("no_verify_error", 32'(error), 0);
`endif
      check("table_queue_empty", exp_q.size(), 0);

      // Runtime write
      @(negedge clk);
      wr_req = 1'b1; wr_addr = 8'h06; wr_data = 8'h3F;
      exp_q.push_back(24'h08063F);
      wait_ack("rt_ack", sr);
      check("rt_ack_ready", 32'(ready), 0);
      check("rt_ack_busy", 32'(busy), 1);
      wr_req = 1'b0;
      @(posedge clk); #1;
      check("rt_ack_pulse", 32'(wr_ack), 0);
      check("rt_clatch_next", 32'(clatch_n), 0);
      wr_addr = '0; wr_data = '0;
      wait_ready("rt_ready");

      // start and wr_req together: table rerun first
      @(negedge clk);
      start = 1'b1; wr_req = 1'b1; wr_addr = 8'h0A; wr_data = 8'h55;
      push_table();
      exp_q.push_back(24'h080A55);
      @(posedge clk); #1;
      start = 1'b0;
      check("start_no_ack", 32'(wr_ack), 0);
      check("start_busy", 32'(busy), 1);
      check("start_idx", 32'(tbl_idx), 0);
      wait_ack("pend_ack", sr);
      check("pend_ack_after_ready", 32'(sr), 1);
      check("pend_ack_table_done", exp_q.size(), 1);
      wr_req = 1'b0;
      @(posedge clk); #1;
      wait_ready("pend_ready");

      // Reset in the middle of a runtime frame (bit 10)
      @(negedge clk);
      wr_req = 1'b1; wr_addr = 8'h11; wr_data = 8'h22;
      wait_ack("abort_ack", sr);
      wr_req = 1'b0;
      n_w = 0;
      while (!(clatch_n === 1'b0 && mon_rises == 14) && n_w < 500) begin
         @(posedge clk); #1; n_w++;
      end
      check("abort_reach_bit10", 32'(mon_rises), 14);
      @(negedge clk);
      aborting = 1'b1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("abort_clatch_n", 32'(clatch_n), 1);
      check("abort_cclk", 32'(cclk), 0);
      check("abort_busy", 32'(busy), 1);
      check("abort_idx", 32'(tbl_idx), 0);
      push_table();
      @(negedge clk); rst_n = 1'b1;
      count_por("abort_por_latency");
      wait_ready("abort_ready");

      repeat (4) @(posedge clk);
      #1;
      check("final_queue_empty", exp_q.size(), 0);
      check("gap_idle_levels", gap_bad, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
